// File: rtl/sorted_stream_out.sv
// sorted_stream_out: captures a ranked 5-value block and streams it out one
// beat per handshake in rank order, flagging blocks whose ranks are not a permutation.
module sorted_stream_out #(
    parameter bit DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] i0,
    input  logic [5:0] i1,
    input  logic [5:0] i2,
    input  logic [5:0] i3,
    input  logic [5:0] i4,
    input  logic [5:0] rank0,
    input  logic [5:0] rank1,
    input  logic [5:0] rank2,
    input  logic [5:0] rank3,
    input  logic [5:0] rank4,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       perm_err
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state, state_nx;
    logic [2:0] pos, pos_nx;
    logic [5:0] val [5];
    logic [2:0] rk [5];
    logic [5:0] vin [5];
    logic [5:0] rin [5];
    logic [4:0] seen;
    logic       in_range, ranks_ok, accept, beat, err_nx;
    logic [2:0] target;

    assign vin = '{i0, i1, i2, i3, i4};
    assign rin = '{rank0, rank1, rank2, rank3, rank4};

    // five in-range ranks covering all of 0..4 are necessarily distinct
    always_comb begin
        seen = '0;
        in_range = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (rin[n] > 6'd4) in_range = 1'b0;
            else seen = seen | (5'd1 << rin[n][2:0]);
        end
        ranks_ok = in_range && (&seen);
    end

    assign out_valid = state == EMIT;
    assign out_last  = out_valid && pos == 3'd4;
    assign in_ready  = (state == IDLE) || (out_last && out_ready);
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign target    = DESCEND ? 3'd4 - pos : pos;

    always_comb begin
        out_data = '0;
        out_idx  = '0;
        for (int n = 0; n < 5; n++) begin
            if (out_valid && rk[n] == target) begin
                out_data = val[n];
                out_idx  = 3'(n);
            end
        end
    end

    // an accept in EMIT only happens on the final beat, so it overrides the block end
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        err_nx   = 1'b0;
        if (beat) begin
            pos_nx = pos + 3'd1;
            if (out_last) begin
                state_nx = IDLE;
                pos_nx   = '0;
            end
        end
        if (accept) begin
            state_nx = ranks_ok ? EMIT : IDLE;
            pos_nx   = '0;
            err_nx   = !ranks_ok;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pos      <= '0;
            perm_err <= 1'b0;
            for (int n = 0; n < 5; n++) begin
                val[n] <= '0;
                rk[n]  <= '0;
            end
        end else begin
            state    <= state_nx;
            pos      <= pos_nx;
            perm_err <= err_nx;
            if (accept) begin
                for (int n = 0; n < 5; n++) begin
                    val[n] <= vin[n];
                    rk[n]  <= rin[n][2:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_sorted_stream_out.sv
// tb_sorted_stream_out: scoreboard bench driving ascending and descending
// instances with the same blocks and checking every presented beat.
module tb_sorted_stream_out;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [5:0] vi [5];
    logic [5:0] ri [5];
    logic       ir [2];
    logic       ov [2];
    logic       ol [2];
    logic       pe [2];
    logic [5:0] od [2];
    logic [2:0] oi [2];

    int vectors = 0;
    int miscompares = 0;
    int expq [2][$];
    bit perm_due [2];
    bit auto_rdy = 1'b0;
    int run = 0;
    int max_run = 0;

    always #5 clk = ~clk;

    sorted_stream_out #(.DESCEND(1'b0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
        .i0(vi[0]), .i1(vi[1]), .i2(vi[2]), .i3(vi[3]), .i4(vi[4]),
        .rank0(ri[0]), .rank1(ri[1]), .rank2(ri[2]), .rank3(ri[3]), .rank4(ri[4]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_idx(oi[0]),
        .out_last(ol[0]), .perm_err(pe[0])
    );

    sorted_stream_out #(.DESCEND(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
        .i0(vi[0]), .i1(vi[1]), .i2(vi[2]), .i3(vi[3]), .i4(vi[4]),
        .rank0(ri[0]), .rank1(ri[1]), .rank2(ri[2]), .rank3(ri[3]), .rank4(ri[4]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_idx(oi[1]),
        .out_last(ol[1]), .perm_err(pe[1])
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic bit perm_ok();
        bit seen [5];
        for (int n = 0; n < 5; n++) seen[n] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (ri[n] > 6'd4) return 1'b0;
            if (seen[ri[n]]) return 1'b0;
            seen[ri[n]] = 1'b1;
        end
        return 1'b1;
    endfunction

    // Reference: place each value at its rank slot, then read slots forward / backward.
    task automatic push_model();
        int slot [5];
        if (!perm_ok()) begin
            perm_due[0] = 1'b1;
            perm_due[1] = 1'b1;
        end else begin
            for (int n = 0; n < 5; n++) slot[ri[n]] = (n << 6) | int'(vi[n]);
            for (int t = 0; t < 5; t++) begin
                expq[0].push_back(slot[t] | (t == 4 ? 512 : 0));
                expq[1].push_back(slot[4 - t] | (t == 4 ? 512 : 0));
            end
        end
    endtask

    task automatic send(input logic [29:0] v, input logic [29:0] r);
        int to = 0;
        #1;
        for (int n = 0; n < 5; n++) begin
            vi[n] = v[6*n +: 6];
            ri[n] = r[6*n +: 6];
        end
        in_valid = 1'b1;
        @(negedge clk);
        while (!ir[0]) begin
            to++;
            if (to > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL in_ready_timeout got=0 want=1");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        push_model();
    endtask

    task automatic idle(input int n);
        #1 in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic gen(input int kind, output logic [29:0] v, output logic [29:0] r);
        int val [5];
        int rk [5];
        for (int n = 0; n < 5; n++) val[n] = int'($urandom_range(0, 63));
        for (int n = 0; n < 5; n++) begin
            rk[n] = 0;
            for (int m = 0; m < 5; m++) if (val[m] * 8 + m < val[n] * 8 + n) rk[n]++;
        end
        if (kind == 1) begin
            for (int k = 4; k > 0; k--) begin
                int j = int'($urandom_range(0, k));
                int t = rk[k];
                rk[k] = rk[j];
                rk[j] = t;
            end
        end
        if (kind == 2) begin
            int a = int'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) rk[a] = int'($urandom_range(5, 63));
            else rk[a] = rk[(a + 1 + int'($urandom_range(0, 3))) % 5];
        end
        for (int n = 0; n < 5; n++) begin
            v[6*n +: 6] = 6'(val[n]);
            r[6*n +: 6] = 6'(rk[n]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_rdy) out_ready = $urandom_range(0, 3) != 0;
        end
    end

    always @(negedge clk) begin
        run = ov[0] ? run + 1 : 0;
        if (run > max_run) max_run = run;
        for (int d = 0; d < 2; d++) begin
            if (pe[d] || perm_due[d]) check($sformatf("perm_err%0d", d), 16'(pe[d]), 16'(perm_due[d]));
            perm_due[d] = 1'b0;
            if (ov[d]) begin
                if (expq[d].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat%0d got=%0h want=none", d, {ol[d], oi[d], od[d]});
                end else begin
                    check($sformatf("beat%0d", d), {6'b0, ol[d], oi[d], od[d]}, 16'(expq[d][0]));
                    if (out_ready) void'(expq[d].pop_front());
                end
            end
        end
    end

    localparam logic [29:0] VA  = {6'd7, 6'd1, 6'd9, 6'd3, 6'd5};
    localparam logic [29:0] RA  = {6'd3, 6'd0, 6'd4, 6'd1, 6'd2};
    localparam logic [29:0] RD  = {6'd4, 6'd3, 6'd1, 6'd1, 6'd0};
    localparam logic [29:0] RR  = {6'd3, 6'd0, 6'd5, 6'd1, 6'd2};
    localparam logic [29:0] VB  = {6'd40, 6'd2, 6'd63, 6'd0, 6'd17};
    localparam logic [29:0] RB  = {6'd3, 6'd1, 6'd4, 6'd0, 6'd2};

    initial begin
        logic [29:0] gv, gr;
        for (int n = 0; n < 5; n++) begin
            vi[n] = '0;
            ri[n] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset_outs%0d", d), {4'b0, ov[d], ol[d], pe[d], oi[d], od[d]}, 16'h0);
        reset = 1'b0;
        #1 check("in_ready_after_reset", 16'(ir[0]), 16'h1);

        send(VA, RA);
        idle(0);
        check("latency_one", 16'(ov[0]), 16'h1);
        repeat (6) @(posedge clk);

        send(VA, RA);
        idle(0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (6) @(posedge clk);

        send(VA, RD);
        idle(3);
        send(VA, RR);
        idle(3);

        max_run = 0;
        send(VA, RA);
        send(VB, RB);
        idle(8);
        check("back_to_back_run", 16'(max_run), 16'd10);

        send(VA, RA);
        idle(0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++)
            check($sformatf("async_reset%0d", d), {13'b0, ov[d], ol[d], pe[d]}, 16'h0);
        for (int d = 0; d < 2; d++) begin
            expq[d].delete();
            perm_due[d] = 1'b0;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("in_ready_after_midreset", 16'(ir[0]), 16'h1);
        idle(8);

        auto_rdy = 1'b1;
        for (int k = 0; k < 80; k++) begin
            gen($urandom_range(0, 9) < 7 ? int'($urandom_range(0, 1)) : 2, gv, gr);
            send(gv, gr);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
        end
        idle(0);
        auto_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int k = 0; k < 200 && (expq[0].size() != 0 || expq[1].size() != 0); k++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("drain_asc", 16'(expq[0].size()), 16'h0);
        check("drain_desc", 16'(expq[1].size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
